fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the IDU wrapper. It owns the fetch program counter and issues one request per cycle to a synchronous instruction memory with fixed 1-cycle read latency. Each returned instruction is buffered, with its PC, in a 2-entry fetch queue. It presents one instruction per cycle to decode on `Instruction_Code`/`pc_in`/`new_valid_in`, honouring decode's `stall` backpressure and redirecting on `flush`.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: decode handshake, redirect request and instruction-memory port.
interface fetch_unit_if #(
  parameter int FETCH_WIDTH     = 1,
  parameter int INST_ADDR_WIDTH = 32
);
  logic                         stall;
  logic                         flush;
  logic [INST_ADDR_WIDTH-1:0]   redirect_pc;
  logic                         imem_req;
  logic [INST_ADDR_WIDTH-1:0]   imem_addr;
  logic [31:0]                  imem_rdata;
  logic [32*FETCH_WIDTH-1:0]    Instruction_Code;
  logic [INST_ADDR_WIDTH-1:0]   pc_in;
  logic [INST_ADDR_WIDTH-1:0]   pc_plus_4_in;
  logic                         new_valid_in;

  // Fetch unit side.
  modport master (
    input  stall, flush, redirect_pc, imem_rdata,
    output imem_req, imem_addr, Instruction_Code, pc_in, pc_plus_4_in, new_valid_in
  );

  // Environment side: decode plus instruction memory.
  modport slave (
    output stall, flush, redirect_pc, imem_rdata,
    input  imem_req, imem_addr, Instruction_Code, pc_in, pc_plus_4_in, new_valid_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues one request per cycle to a
// 1-cycle-latency memory and buffers returned instructions in a 2-entry queue.
// Requests are credit-limited so every in-flight response always has a slot.
module fetch_unit #(
  parameter int                         FETCH_WIDTH     = 1,
  parameter int                         INST_ADDR_WIDTH = 32,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int W = INST_ADDR_WIDTH;

  logic [W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [W-1:0]  pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [31:0]   instr_q [2];
  logic [31:0]   instr_d [2];
  logic [W-1:0]  epc_q   [2];
  logic [W-1:0]  epc_d   [2];

  logic          pop;
  logic          push;
  logic          issue;
  logic [2:0]    occupancy;

  // Next-state logic: flush overrides everything, otherwise push/pop/issue.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inflight_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    instr_d[0] = instr_q[0];
    instr_d[1] = instr_q[1];
    epc_d[0]   = epc_q[0];
    epc_d[1]   = epc_q[1];

    pop       = (count_q != 2'd0) && !bus.stall;
    push      = inflight_q && !bus.flush;
    // Slots already promised (held + in flight) after this cycle's pop.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    // Gating with reset keeps the request low while reset is held.
    issue     = reset && !bus.flush && (occupancy < 3'd2);

    if (bus.flush) begin
      fetch_pc_d = {bus.redirect_pc[W-1:2], 2'b00};
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + W'(4);
        pc_d       = fetch_pc_q;
      end
      if (push) begin
        instr_d[wr_ptr_q] = bus.imem_rdata;
        epc_d[wr_ptr_q]   = pc_q;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers; payloads are cleared too so outputs read zero in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      epc_q[0]   <= '0;
      epc_q[1]   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instr_q[0] <= instr_d[0];
      instr_q[1] <= instr_d[1];
      epc_q[0]   <= epc_d[0];
      epc_q[1]   <= epc_d[1];
    end
  end

  // Output mapping: head entry straight from the queue registers, lanes above 0 tied off.
  always_comb begin
    bus.Instruction_Code       = '0;
    bus.Instruction_Code[31:0] = instr_q[rd_ptr_q];
    bus.pc_in                  = epc_q[rd_ptr_q];
    bus.pc_plus_4_in           = epc_q[rd_ptr_q] + W'(4);
    bus.new_valid_in           = (count_q != 2'd0);
    bus.imem_req               = issue;
    bus.imem_addr              = fetch_pc_q;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model word[i] = i, expected PC stream per
// redirect kept in a scoreboard queue, directed checks queued for the monitor.
module tb_fetch_unit;
  localparam int AW = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.FETCH_WIDTH(1), .INST_ADDR_WIDTH(AW)) ifc ();

  fetch_unit #(
    .FETCH_WIDTH    (1),
    .INST_ADDR_WIDTH(AW),
    .RESET_PC       (16'h0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  typedef struct {
    int          sel;
    logic [31:0] val;
  } dchk_t;

  logic [AW-1:0] exp_q [$];
  dchk_t         dir_q [$];

  // Synchronous memory, 1-cycle latency; garbage when no request was made.
  always @(posedge clk) begin
    if (ifc.imem_req) ifc.imem_rdata <= 32'(ifc.imem_addr >> 2);
    else              ifc.imem_rdata <= 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] sig_val(input int sel);
    case (sel)
      0:       return {31'b0, ifc.new_valid_in};
      1:       return 32'(ifc.pc_in);
      2:       return ifc.Instruction_Code;
      3:       return 32'(ifc.pc_plus_4_in);
      4:       return {31'b0, ifc.imem_req};
      default: return 32'(ifc.imem_addr);
    endcase
  endfunction

  function automatic string sig_name(input int sel);
    case (sel)
      0:       return "new_valid_in";
      1:       return "pc_in";
      2:       return "Instruction_Code";
      3:       return "pc_plus_4_in";
      4:       return "imem_req";
      default: return "imem_addr";
    endcase
  endfunction

  task automatic expect_now(input int sel, input logic [31:0] v);
    dchk_t c;
    c.sel = sel;
    c.val = v;
    dir_q.push_back(c);
  endtask

  task automatic expect_reset_values();
    expect_now(0, 32'd0);
    expect_now(1, 32'd0);
    expect_now(2, 32'd0);
    expect_now(3, 32'd4);
    expect_now(4, 32'd0);
    expect_now(5, 32'd0);
  endtask

  // Expected output stream after a redirect: consecutive words from start.
  task automatic seed(input logic [AW-1:0] start);
    exp_q.delete();
    for (int i = 0; i < 700; i++) exp_q.push_back(start + AW'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains directed checks, then scores every consumed instruction.
  always @(negedge clk) begin
    dchk_t         c;
    logic [AW-1:0] e;
    while (dir_q.size() > 0) begin
      c = dir_q.pop_front();
      checks++;
      if (sig_val(c.sel) !== c.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", sig_name(c.sel), sig_val(c.sel), c.val, $time);
      end
    end
    if (reset && ifc.new_valid_in && !ifc.stall && !ifc.flush) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got pc %h expected no output", ifc.pc_in);
      end else begin
        e = exp_q.pop_front();
        checks += 3;
        if (ifc.pc_in !== e) begin
          errors++;
          $display("FAIL sb_pc: got %h expected %h at %0t", ifc.pc_in, e, $time);
        end
        if (ifc.Instruction_Code !== 32'(e >> 2)) begin
          errors++;
          $display("FAIL sb_instr: got %h expected %h at %0t", ifc.Instruction_Code, 32'(e >> 2), $time);
        end
        if (ifc.pc_plus_4_in !== AW'(e + AW'(4))) begin
          errors++;
          $display("FAIL sb_pc4: got %h expected %h at %0t", ifc.pc_plus_4_in, AW'(e + AW'(4)), $time);
        end
      end
    end
  end

  // Driver: directed scenarios followed by a randomized stall/flush phase.
  initial begin
    logic [AW-1:0] rpc;
    ifc.stall       = 1'b0;
    ifc.flush       = 1'b0;
    ifc.redirect_pc = '0;
    reset           = 1'b0;
    repeat (3) step();
    expect_reset_values();

    // Reset release and first-fetch latency.
    step();
    reset = 1'b1;
    seed(16'h0000);
    expect_now(4, 32'd1);
    expect_now(5, 32'h0);
    expect_now(0, 32'd0);
    step();
    expect_now(0, 32'd0);
    expect_now(4, 32'd1);
    expect_now(5, 32'h4);
    step();
    expect_now(0, 32'd1);
    expect_now(1, 32'h0);
    expect_now(2, 32'h0);
    expect_now(3, 32'h4);
    step();
    step();

    // Stall for five cycles: head frozen at pc 12, requests throttled.
    for (int i = 0; i < 5; i++) begin
      step();
      ifc.stall = 1'b1;
      expect_now(0, 32'd1);
      expect_now(1, 32'd12);
      expect_now(2, 32'd3);
      expect_now(4, 32'd0);
    end
    step();
    ifc.stall = 1'b0;
    repeat (3) step();

    // Flush while streaming.
    step();
    ifc.flush       = 1'b1;
    ifc.redirect_pc = 16'h0100;
    seed(16'h0100);
    expect_now(4, 32'd0);
    step();
    ifc.flush = 1'b0;
    expect_now(0, 32'd0);
    expect_now(4, 32'd1);
    expect_now(5, 32'h100);
    step();
    expect_now(0, 32'd0);
    expect_now(5, 32'h104);
    step();
    expect_now(0, 32'd1);
    expect_now(1, 32'h100);
    expect_now(2, 32'h40);
    repeat (2) step();

    // Fill the queue under stall, then flush together with stall.
    repeat (3) begin
      step();
      ifc.stall = 1'b1;
    end
    step();
    ifc.flush       = 1'b1;
    ifc.redirect_pc = 16'h0203;
    seed(16'h0200);
    expect_now(4, 32'd0);
    step();
    ifc.flush = 1'b0;
    ifc.stall = 1'b0;
    expect_now(0, 32'd0);
    expect_now(4, 32'd1);
    expect_now(5, 32'h200);
    step();
    step();
    expect_now(0, 32'd1);
    expect_now(1, 32'h200);
    expect_now(2, 32'h80);

    // Address wrap at the top of the space.
    step();
    ifc.flush       = 1'b1;
    ifc.redirect_pc = 16'hFFF8;
    seed(16'hFFF8);
    step();
    ifc.flush = 1'b0;
    expect_now(5, 32'hFFF8);
    step();
    expect_now(5, 32'hFFFC);
    step();
    expect_now(5, 32'h0);
    expect_now(0, 32'd1);
    expect_now(1, 32'hFFF8);
    step();
    expect_now(1, 32'hFFFC);
    expect_now(3, 32'h0);
    step();
    expect_now(1, 32'h0);
    expect_now(3, 32'h4);
    repeat (2) step();

    // Asynchronous reset mid-stream with one entry queued and one in flight.
    step();
    reset = 1'b0;
    seed(16'h0000);
    expect_reset_values();
    step();
    reset = 1'b1;
    expect_now(0, 32'd0);
    expect_now(4, 32'd1);
    expect_now(5, 32'h0);
    step();
    expect_now(0, 32'd0);
    step();
    expect_now(0, 32'd1);
    expect_now(1, 32'h0);
    expect_now(2, 32'h0);

    // Randomized stall/flush traffic.
    for (int i = 0; i < 600; i++) begin
      step();
      ifc.stall = ($urandom_range(0, 2) == 0);
      ifc.flush = ($urandom_range(0, 24) == 0);
      if (ifc.flush) begin
        rpc             = AW'($urandom);
        ifc.redirect_pc = rpc;
        seed({rpc[AW-1:2], 2'b00});
      end
    end
    step();
    ifc.stall = 1'b0;
    ifc.flush = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
